// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
//   Round-robin arbiter sharing one 2-to-4 decoded resource among four
//   requesters. It grants one requester at a time and drives both the binary
//   select (gnt_idx) and the one-hot grant (gnt). Each grant is held for at
//   most HOLD_MAX cycles. At that limit the arbiter forces a release and
//   raises a one-cycle timeout pulse.
//
//   Ports
//     clk        in   1  system clock, rising edge
//     rst_n      in   1  asynchronous active-low reset
//     en         in   1  arbiter enable; 0 blocks new grants and aborts the active one
//     req        in   4  level requests, bit i = requester i
//     done       in   1  active holder releases the grant this cycle
//     gnt        out  4  one-hot grant, 0 when idle
//     gnt_idx    out  2  binary index of the granted requester (decoder select)
//     gnt_valid  out  1  a grant is active (decoder enable)
//     timeout    out  1  one-cycle pulse when a grant is forcibly ended
//
//   All outputs are registered. gnt always equals
//   (gnt_valid ? 1 << gnt_idx : 0).

module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q,   ptr_d;
  logic [1:0]      idx_q,   idx_d;
  logic            valid_q, valid_d;
  logic            to_q,    to_d;
  logic [3:0]      gnt_q,   gnt_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic [1:0]      pick;
  logic            pick_found;
  logic [1:0]      cand;

  // Rotating priority scan: ptr, ptr+1, ... wrapping through the 2-bit add.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + i[1:0];
      if (!pick_found && req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (en && pick_found) begin
          idx_d   = pick;
          valid_d = 1'b1;
          cnt_d   = CW'(1);
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (!en) begin
          // Abort leaves the rotation pointer where it was.
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (done || !req[idx_q]) begin
          // A voluntary release takes precedence over the hold limit, so
          // done arriving together with cnt == HOLD_MAX raises no timeout.
          valid_d = 1'b0;
          cnt_d   = '0;
          ptr_d   = idx_q + 2'd1;
          state_d = IDLE;
        end else if (cnt_q == CW'(HOLD_MAX)) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          ptr_d   = idx_q + 2'd1;
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // The one-hot grant is decoded ahead of the register so that it stays
    // cycle-aligned with gnt_idx and gnt_valid.
    gnt_d = valid_d ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4
//   Scoreboard bench for rr_arbiter_4 with HOLD_MAX = 8. The stimulus process
//   queues the expected grant (index, tenure in cycles, timeout at end) and
//   then drives the inputs. The monitor samples on the falling edge, pops an
//   entry at each rising gnt_valid, and checks the index, tenure, timeout
//   pulse and gnt encoding.

module tb_rr_arbiter_4;

  localparam int unsigned HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  idx;
    int unsigned len;
    logic        to;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_4 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input string name, input logic lvl, input int unsigned lim);
    int unsigned n = 0;
    while (gnt_valid !== lvl && n < lim) begin
      step();
      n++;
    end
    chk(name, {31'd0, gnt_valid}, {31'd0, lvl});
  endtask

  task automatic push(input logic [1:0] idx, input int unsigned len, input logic to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  // Monitor state
  exp_t        cur;
  logic        active = 1'b0;
  logic        prev   = 1'b0;
  int unsigned len    = 0;
  logic [3:0]  exp_g;
  logic        exp_to;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      prev   = 1'b0;
    end else begin
      exp_g = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL gnt_onehot: got %b expected %b", gnt, exp_g);
      end

      if (gnt_valid && !prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          active = 1'b0;
          $display("FAIL unexpected_grant: got idx %0d expected no grant", gnt_idx);
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          len    = 1;
          if (gnt_idx !== cur.idx) begin
            errors++;
            $display("FAIL grant_idx: got %0d expected %0d", gnt_idx, cur.idx);
          end
        end
      end else if (gnt_valid) begin
        len++;
      end

      exp_to = (!gnt_valid && prev && active) ? cur.to : 1'b0;
      checks++;
      if (timeout !== exp_to) begin
        errors++;
        $display("FAIL timeout_pulse: got %b expected %b", timeout, exp_to);
      end

      if (!gnt_valid && prev && active) begin
        checks++;
        if (len != cur.len) begin
          errors++;
          $display("FAIL tenure: got %0d expected %0d (idx %0d)", len, cur.len, cur.idx);
        end
        active = 1'b0;
      end

      prev = gnt_valid;
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    chk("reset_gnt",       {28'd0, gnt},       32'd0);
    chk("reset_gnt_idx",   {30'd0, gnt_idx},   32'd0);
    chk("reset_gnt_valid", {31'd0, gnt_valid}, 32'd0);
    chk("reset_timeout",   {31'd0, timeout},   32'd0);
    step();
    step();

    // Grant idx 0, then assert reset in the middle of the grant.
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 4'b0001;
    wait_level("wait_first_grant", 1'b1, 5);
    chk("first_grant_gnt", {28'd0, gnt}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gnt",       {28'd0, gnt},       32'd0);
    chk("async_reset_gnt_valid", {31'd0, gnt_valid}, 32'd0);
    chk("async_reset_timeout",   {31'd0, timeout},   32'd0);
    step();
    step();

    // Rotation with all four requesting; pointer starts at 0 after reset.
    rst_n = 1'b1;
    req   = 4'b1111;
    push(2'd0, 1, 1'b0);
    push(2'd1, 1, 1'b0);
    push(2'd2, 1, 1'b0);
    push(2'd3, 1, 1'b0);
    push(2'd0, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_level("wait_rotation_grant", 1'b1, 5);
      done = 1'b1;
      step();
      done = 1'b0;
      if (k == 4) req = 4'b0000;
    end
    step();

    // With en low, requests produce no grant. The pointer is now 1.
    en  = 1'b0;
    req = 4'b1111;
    repeat (4) step();
    chk("no_grant_when_disabled", {31'd0, gnt_valid}, 32'd0);
    req = 4'b0000;
    en  = 1'b1;
    step();

    // A single requester (idx 2) is released by done, which moves the pointer to 3.
    push(2'd2, 1, 1'b0);
    req = 4'b0100;
    wait_level("wait_single_grant", 1'b1, 5);
    chk("single_gnt", {28'd0, gnt}, 32'h4);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    chk("single_release_gnt", {28'd0, gnt}, 32'd0);
    step();

    // Wrap case: ptr=3 and req=0011 select 0, then 1.
    push(2'd0, 1, 1'b0);
    push(2'd1, 1, 1'b0);
    req = 4'b0011;
    wait_level("wait_wrap_grant0", 1'b1, 5);
    done = 1'b1;
    step();
    done = 1'b0;
    wait_level("wait_wrap_grant1", 1'b1, 5);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();

    // Hold limit: idx 1 times out after 8 cycles and is regranted after the bubble.
    push(2'd1, HOLD, 1'b1);
    push(2'd1, 1, 1'b0);
    req = 4'b0010;
    wait_level("wait_timeout_grant", 1'b1, 5);
    wait_level("wait_timeout_release", 1'b0, 20);
    chk("timeout_pulse_direct", {31'd0, timeout}, 32'd1);
    wait_level("wait_regrant", 1'b1, 5);
    req = 4'b0000;
    step();
    step();

    // done together with cnt == HOLD_MAX is a normal release with no timeout.
    push(2'd1, HOLD, 1'b0);
    req = 4'b0010;
    wait_level("wait_limit_done_grant", 1'b1, 5);
    repeat (HOLD - 1) step();
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    chk("limit_done_no_timeout", {31'd0, timeout}, 32'd0);
    step();

    // en=0 together with done aborts and leaves ptr at 2. req=1110 then
    // separates ptr=2 (grants 2) from ptr=3 (would grant 3).
    push(2'd2, 1, 1'b0);
    push(2'd2, 1, 1'b0);
    req = 4'b0100;
    wait_level("wait_abort_grant", 1'b1, 5);
    en   = 1'b0;
    done = 1'b1;
    step();
    chk("abort_gnt", {28'd0, gnt}, 32'd0);
    en   = 1'b1;
    done = 1'b0;
    req  = 4'b1110;
    wait_level("wait_after_abort", 1'b1, 5);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    repeat (3) step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
